riscv_next_strategy_random_mc: RTL

Multi-channel, configurable random jump-predictor strategy for the `USE_JUMP_PREDICTOR` build. It generates pseudo-random PC-relative inject targets for the program-memory fetch path through the standard `riscv_next_strategy_from_pm_intf`. Compared with the single-generator random strategy, it adds:
- interleaved generator channels;
- a runtime seed, injection rate, direction mode and cooldown;
- stall awareness;
- a saturating inject counter for coverage and statistics.

---
 rtl/riscv_next_strategy_pkg.sv | 34 +++
 rtl/riscv_next_strategy_from_pm_intf.sv | 14 +
 rtl/riscv_next_strategy_random_mc_rng.sv | 34 +++
 rtl/riscv_next_strategy_random_mc.sv | 128 ++++++++++++
 4 files changed

// File: rtl/riscv_next_strategy_pkg.sv
// Shared constants, direction-mode enum and generator helpers for the
// random jump-predictor strategy.
package riscv_next_strategy_pkg;

  localparam logic [31:0] INIT_STATE = 32'd2463534242;
  localparam logic [31:0] MULTIPLIER = 32'd3084775641;
  localparam logic [31:0] GOLDEN     = 32'h9E3779B9;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_ANY = 2'd1,
    MODE_FWD = 2'd2,
    MODE_BWD = 2'd3
  } next_mode_e;

  // One xorshift32 step (13, 17, 5).
  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Per-channel seed; an all-zero state would lock xorshift, so it is replaced.
  function automatic logic [31:0] channel_seed(input logic [31:0] base,
                                               input logic [31:0] index);
    logic [31:0] s;
    s = base ^ (index * GOLDEN);
    return (s == 32'd0) ? INIT_STATE : s;
  endfunction

endpackage

// File: rtl/riscv_next_strategy_from_pm_intf.sv
// Program-memory fetch path <-> next-PC strategy interface.
//   i_pm_pc       : current fetch PC (driven by fetch)
//   o_inject      : strategy requests a jump injection
//   o_inject_addr : injected target address
interface riscv_next_strategy_from_pm_intf #(
  parameter int unsigned ADDR_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] i_pm_pc;
  logic                  o_inject;
  logic [ADDR_WIDTH-1:0] o_inject_addr;

  modport strategy (input i_pm_pc, output o_inject, output o_inject_addr);
  modport pm       (output i_pm_pc, input o_inject, input o_inject_addr);
endinterface

// File: rtl/riscv_next_strategy_random_mc_rng.sv
// One xorshift32 generator channel with seed load, step enable and a
// multiplicative scrambler on the output.
//   clk, nreset : clock, synchronous active-low reset
//   load, seed  : load channel_seed(seed, INDEX) into the state
//   step        : advance the state by one xorshift32 step
//   r           : upper 32 bits of state * MULTIPLIER
module rng_xorshift32_ch
  import riscv_next_strategy_pkg::*;
#(
  parameter int unsigned INDEX = 0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] r
);

  logic [31:0] state;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= INIT_STATE;
    end else if (load) begin
      state <= channel_seed(seed, 32'(INDEX));
    end else if (step) begin
      state <= xorshift32(state);
    end
  end

  assign r = 32'((64'(state) * 64'(MULTIPLIER)) >> 32);

endmodule

// File: rtl/riscv_next_strategy_random_mc.sv
// Multi-channel random jump-predictor strategy: interleaved xorshift
// generators propose PC-relative inject targets, gated by a runtime rate,
// direction mode and cooldown, with a saturating inject counter.
//   clk, nreset      : clock, synchronous active-low reset
//   enable           : block enable
//   i_stall          : freezes all state
//   i_cfg_*          : one-cycle config load (seed, rate, mode, cooldown)
//   o_inject_cnt     : saturating count of consumed injects
//   intf             : i_pm_pc in, o_inject / o_inject_addr out (combinational)
module riscv_next_strategy_random_mc
  import riscv_next_strategy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned OFFSET     = 5,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned RATE_BITS  = 4,
  parameter int unsigned CD_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 enable,
  input  logic                 i_stall,
  input  logic                 i_cfg_we,
  input  logic [31:0]          i_cfg_seed,
  input  logic [RATE_BITS-1:0] i_cfg_rate,
  input  logic [1:0]           i_cfg_mode,
  input  logic [CD_BITS-1:0]   i_cfg_cooldown,
  output logic [15:0]          o_inject_cnt,
  riscv_next_strategy_from_pm_intf.strategy intf
);

  localparam int unsigned PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [ADDR_WIDTH-1:0] last_pc;
  logic [PTR_W-1:0]      ptr;
  next_mode_e            mode;
  logic [RATE_BITS-1:0]  rate;
  logic [CD_BITS-1:0]    cd_cfg;
  logic [CD_BITS-1:0]    cd_cnt;
  logic [15:0]           inject_cnt;

  logic                  cfg_load;
  logic                  adv;
  logic [31:0]           ch_r [CHANNELS];
  logic [31:0]           r_sel;
  logic [OFFSET-1:0]     f;
  logic                  inject;
  logic [ADDR_WIDTH-1:0] inject_addr;
  logic                  unused_r_bits;

  // Config is frozen by stall like everything else; it wins over a new PC.
  assign cfg_load = i_cfg_we && !i_stall;
  assign adv      = enable && !i_stall && !i_cfg_we && (intf.i_pm_pc != last_pc);

  // Generator channels; only the pointed-to channel steps on a new PC.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    rng_xorshift32_ch #(.INDEX(g)) u_ch (
      .clk    (clk),
      .nreset (nreset),
      .load   (cfg_load),
      .seed   (i_cfg_seed),
      .step   (adv && (ptr == PTR_W'(g))),
      .r      (ch_r[g])
    );
  end

  // Selected channel output.
  always_comb begin
    r_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ptr == PTR_W'(k)) r_sel = ch_r[k];
    end
  end

  assign unused_r_bits = ^r_sel;

  // Offset field with the direction bit forced by mode.
  always_comb begin
    f = r_sel[OFFSET-1:0];
    if (mode == MODE_FWD) f[OFFSET-1] = 1'b0;
    if (mode == MODE_BWD) f[OFFSET-1] = 1'b1;
  end

  // Offsets 0 and +1 word would just re-fetch the sequential path.
  assign inject = (mode != MODE_OFF) && enable && nreset &&
                  (f > OFFSET'(1)) &&
                  (r_sel[31 -: RATE_BITS] < rate) &&
                  (cd_cnt == '0);

  assign inject_addr = nreset
                     ? (intf.i_pm_pc + ADDR_WIDTH'($signed({f, 2'b00})))
                     : '0;

  assign intf.o_inject      = inject;
  assign intf.o_inject_addr = inject_addr;
  assign o_inject_cnt       = inject_cnt;

  // Config, PC tracking, channel pointer, cooldown and statistics.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      last_pc    <= '0;
      ptr        <= '0;
      mode       <= MODE_OFF;
      rate       <= '0;
      cd_cfg     <= '0;
      cd_cnt     <= '0;
      inject_cnt <= '0;
    end else if (cfg_load) begin
      mode   <= next_mode_e'(i_cfg_mode);
      rate   <= i_cfg_rate;
      cd_cfg <= i_cfg_cooldown;
      cd_cnt <= '0;
      ptr    <= '0;
    end else if (adv) begin
      last_pc <= intf.i_pm_pc;
      ptr     <= (ptr == PTR_W'(CHANNELS - 1)) ? '0 : ptr + PTR_W'(1);
      if (inject) begin
        cd_cnt <= cd_cfg;
      end else if (cd_cnt != '0) begin
        cd_cnt <= cd_cnt - CD_BITS'(1);
      end
      if (inject && (inject_cnt != 16'hFFFF)) begin
        inject_cnt <= inject_cnt + 16'd1;
      end
    end
  end

endmodule
